ovl_time_stim_gen: RTL and testbench

- Stimulus-side counterpart to the time-window checker: converts a single-cycle request into a `start_event` pulse followed by a `hold` level lasting exactly `num_cks` cycles.
- The `start_event` and `hold` outputs connect directly to the checker's `start_event` and `test_expr` inputs.
- Used in the OVL self-test benches to produce legal traffic, and, via the action/override controls, deliberate violations.
- Implements the same three new-start policies as the checker, so both ends agree on window semantics.

---
 rtl/ovl_time_stim_gen.sv | 172 +++++++++++++++++
 tb/tb_ovl_time_stim_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_time_stim_gen.sv
// Stimulus generator for the OVL time-window checker: a request becomes a start_event
// pulse followed by a hold level of exactly num_cks cycles, with selectable new-start policy.
module ovl_time_stim_gen #(
  parameter int num_cks             = 1,
  parameter int action_on_new_start = 0,
  parameter int CNT_W               = 8,
  parameter int DROP_W              = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_req,
  input  logic              hold_kill,
  output logic              start_event,
  output logic              hold,
  output logic              busy,
  output logic [CNT_W-1:0]  remaining,
  output logic              done,
  output logic              new_start_err,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  LOAD_VAL   = CNT_W'(num_cks);
  localparam logic [CNT_W-1:0]  RELOAD_VAL = CNT_W'(num_cks + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};
  localparam logic              POL_IGNORE = (action_on_new_start == 0);
  localparam logic              POL_RESET  = (action_on_new_start == 1);
  localparam logic              POL_ERROR  = (action_on_new_start == 2);

  // Illegal parameterisations are rejected at elaboration.
  if ((num_cks < 1) || (num_cks > (2 ** CNT_W) - 2)) begin : g_bad_num_cks
    $error("ovl_error_t: num_cks=%0d outside 1..%0d", num_cks, (2 ** CNT_W) - 2);
  end
  if ((action_on_new_start < 0) || (action_on_new_start > 2)) begin : g_bad_action
    $error("ovl_error_t: action_on_new_start=%0d outside 0..2", action_on_new_start);
  end

  state_t              r_state;
  logic                r_start_event;
  logic                r_hold;
  logic                r_busy;
  logic [CNT_W-1:0]    r_remaining;
  logic                r_done;
  logic                r_new_start_err;
  logic [DROP_W-1:0]   r_drop_cnt;

  state_t              w_state_nxt;
  logic                w_start_event_nxt;
  logic                w_hold_nxt;
  logic                w_busy_nxt;
  logic [CNT_W-1:0]    w_remaining_nxt;
  logic                w_done_nxt;
  logic                w_new_start_err_nxt;
  logic [DROP_W-1:0]   w_drop_cnt_nxt;
  logic                w_new_start;

  assign w_new_start = start_req & (r_state != ST_IDLE);

  // Next-state and next-output decode for the window sequencer.
  always_comb begin
    w_state_nxt         = r_state;
    w_start_event_nxt   = 1'b0;
    w_hold_nxt          = r_hold;
    w_remaining_nxt     = r_remaining;
    w_done_nxt          = 1'b0;
    w_new_start_err_nxt = 1'b0;
    w_drop_cnt_nxt      = r_drop_cnt;

    case (r_state)
      ST_IDLE: begin
        w_hold_nxt      = 1'b0;
        w_remaining_nxt = CNT_ZERO;
        if (start_req) begin
          w_start_event_nxt = 1'b1;
          w_state_nxt       = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        // A restart while armed re-emits the pulse and defers loading by a cycle.
        if (start_req && POL_RESET) begin
          w_start_event_nxt = 1'b1;
          w_state_nxt       = ST_ARM;
        end else begin
          w_hold_nxt      = 1'b1;
          w_remaining_nxt = LOAD_VAL;
          w_state_nxt     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (start_req && POL_RESET) begin
          w_start_event_nxt = 1'b1;
          w_hold_nxt        = 1'b1;
          w_remaining_nxt   = RELOAD_VAL;
          w_state_nxt       = ST_ACTIVE;
        end else if (r_remaining == CNT_ONE) begin
          w_hold_nxt      = 1'b0;
          w_remaining_nxt = CNT_ZERO;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_remaining_nxt = r_remaining - CNT_ONE;
          w_state_nxt     = ST_ACTIVE;
        end
      end
      default: begin
        w_hold_nxt      = 1'b0;
        w_remaining_nxt = CNT_ZERO;
        w_state_nxt     = ST_IDLE;
      end
    endcase

    if (w_new_start && POL_IGNORE) begin
      if (r_drop_cnt != DROP_MAX) begin
        w_drop_cnt_nxt = r_drop_cnt + DROP_ONE;
      end else begin
        w_drop_cnt_nxt = r_drop_cnt;
      end
    end else begin
      w_drop_cnt_nxt = r_drop_cnt;
    end

    if (w_new_start && POL_ERROR) begin
      w_new_start_err_nxt = 1'b1;
    end else begin
      w_new_start_err_nxt = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset abandons any open window without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_start_event   <= 1'b0;
      r_hold          <= 1'b0;
      r_busy          <= 1'b0;
      r_remaining     <= CNT_ZERO;
      r_done          <= 1'b0;
      r_new_start_err <= 1'b0;
      r_drop_cnt      <= {DROP_W{1'b0}};
    end else begin
      r_state         <= w_state_nxt;
      r_start_event   <= w_start_event_nxt;
      r_hold          <= w_hold_nxt;
      r_busy          <= w_busy_nxt;
      r_remaining     <= w_remaining_nxt;
      r_done          <= w_done_nxt;
      r_new_start_err <= w_new_start_err_nxt;
      r_drop_cnt      <= w_drop_cnt_nxt;
    end
  end

  assign start_event   = r_start_event;
  assign hold          = r_hold & ~hold_kill;
  assign busy          = r_busy;
  assign remaining     = r_remaining;
  assign done          = r_done;
  assign new_start_err = r_new_start_err;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_ovl_time_stim_gen.sv
// Self-checking bench for ovl_time_stim_gen: five instances cover the window lengths
// and new-start policies; expected per-cycle outputs are queued and compared each cycle.
module tb_ovl_time_stim_gen;

  typedef struct packed {
    logic       se;
    logic       hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rem;
    logic [7:0] drop;
  } obs_t;

  localparam int NUM [5] = '{3, 4, 4, 2, 5};
  localparam int POL [5] = '{0, 1, 0, 2, 0};

  logic clk = 1'b0;
  logic reset_n;
  logic start_req;
  logic hold_kill;

  logic       se_w   [5];
  logic       hold_w [5];
  logic       busy_w [5];
  logic       done_w [5];
  logic       err_w  [5];
  logic [7:0] rem_w  [5];
  logic [7:0] drop_w [5];
  obs_t       obs_w  [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    ovl_time_stim_gen #(
      .num_cks(NUM[g]),
      .action_on_new_start(POL[g]),
      .CNT_W(8),
      .DROP_W(8)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .start_req(start_req),
      .hold_kill(hold_kill),
      .start_event(se_w[g]),
      .hold(hold_w[g]),
      .busy(busy_w[g]),
      .remaining(rem_w[g]),
      .done(done_w[g]),
      .new_start_err(err_w[g]),
      .drop_cnt(drop_w[g])
    );
    assign obs_w[g] = {se_w[g], hold_w[g], busy_w[g], done_w[g], err_w[g], rem_w[g], drop_w[g]};
  end

  function automatic obs_t mk(bit se, bit hold, bit busy, bit done, bit err, int rem, int drop);
    obs_t o;
    o.se   = se;
    o.hold = hold;
    o.busy = busy;
    o.done = done;
    o.err  = err;
    o.rem  = 8'(rem);
    o.drop = 8'(drop);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("se=%b hold=%b busy=%b done=%b err=%b rem=%0d drop=%0d",
                     o.se, o.hold, o.busy, o.done, o.err, o.rem, o.drop);
  endfunction

  task automatic reset_dut();
    reset_n   = 1'b0;
    start_req = 1'b0;
    hold_kill = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t q[$];
    obs_t got, exp;
    reset_n   = 1'b0;
    start_req = 1'b1;
    hold_kill = 1'b0;
    #2;
    for (int g = 0; g < 5; g++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    for (int g = 0; g < 5; g++) begin
      got = obs_w[g];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset inst=%0d got %s want %s", g, fmt(got), fmt(exp));
      end
    end
    repeat (2) @(posedge clk);
    #2;
    for (int g = 0; g < 5; g++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    for (int g = 0; g < 5; g++) begin
      got = obs_w[g];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_held_req inst=%0d got %s want %s", g, fmt(got), fmt(exp));
      end
    end
    start_req = 1'b0;
  endtask

  task automatic test_basic();
    obs_t q[$];
    obs_t got, exp;
    reset_dut();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10);
      q.push_back(mk(k == 11, k >= 12 && k <= 14, k >= 11 && k <= 14, k == 15, 1'b0,
                     (k >= 12 && k <= 14) ? 15 - k : 0, 0));
      #1 got = obs_w[0];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t q[$];
    obs_t got, exp;
    int   r;
    reset_dut();
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10) || (k == 15);
      r = (k >= 12 && k <= 14) ? 15 - k : (k >= 17 && k <= 19) ? 20 - k : 0;
      q.push_back(mk(k == 11 || k == 16, r != 0,
                     (k >= 11 && k <= 14) || (k >= 16 && k <= 19),
                     k == 15 || k == 20, 1'b0, r, 0));
      #1 got = obs_w[0];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_hold_kill();
    obs_t q[$];
    obs_t got, exp;
    reset_dut();
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10);
      hold_kill = (k == 13);
      q.push_back(mk(k == 11, k >= 12 && k <= 14 && k != 13, k >= 11 && k <= 14, k == 15, 1'b0,
                     (k >= 12 && k <= 14) ? 15 - k : 0, 0));
      #1 got = obs_w[0];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold_kill cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
    hold_kill = 1'b0;
  endtask

  task automatic test_policy_reset();
    obs_t q[$];
    obs_t got, exp;
    int   r;
    reset_dut();
    for (int k = 1; k <= 54; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10) || (k == 13) || (k == 30) || (k == 31) || (k == 40) || (k == 45);
      if (k >= 12 && k <= 13)      r = 16 - k;
      else if (k >= 14 && k <= 18) r = 19 - k;
      else if (k >= 33 && k <= 36) r = 37 - k;
      else if (k >= 42 && k <= 45) r = 46 - k;
      else if (k >= 46 && k <= 50) r = 51 - k;
      else                         r = 0;
      q.push_back(mk(k == 11 || k == 14 || k == 31 || k == 32 || k == 41 || k == 46, r != 0,
                     (k >= 11 && k <= 18) || (k >= 31 && k <= 36) || (k >= 41 && k <= 50),
                     k == 19 || k == 37 || k == 51, 1'b0, r, 0));
      #1 got = obs_w[1];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL policy_reset cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_policy_ignore();
    obs_t q[$];
    obs_t got, exp;
    int   r;
    reset_dut();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1 start_req = (k >= 10 && k <= 15) || (k == 20);
      r = (k >= 12 && k <= 15) ? 16 - k : (k >= 22 && k <= 25) ? 26 - k : 0;
      q.push_back(mk(k == 11 || k == 21, r != 0,
                     (k >= 11 && k <= 15) || (k >= 21 && k <= 25),
                     k == 16 || k == 26, 1'b0, r,
                     (k < 12) ? 0 : (k < 16) ? k - 11 : 5));
      #1 got = obs_w[2];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL policy_ignore cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_policy_error();
    obs_t q[$];
    obs_t got, exp;
    int   r;
    reset_dut();
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10) || (k == 12) || (k == 20) || (k == 21);
      r = (k >= 12 && k <= 13) ? 14 - k : (k >= 22 && k <= 23) ? 24 - k : 0;
      q.push_back(mk(k == 11 || k == 21, r != 0,
                     (k >= 11 && k <= 13) || (k >= 21 && k <= 23),
                     k == 14 || k == 24, k == 13 || k == 22, r, 0));
      #1 got = obs_w[3];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL policy_error cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t q[$];
    obs_t got, exp;
    int   r;
    reset_dut();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1 start_req = (k == 10) || (k == 20);
      if (k == 13)      reset_n = 1'b0;
      else if (k == 15) reset_n = 1'b1;
      else              reset_n = reset_n;
      r = (k == 12) ? 5 : (k >= 22 && k <= 26) ? 27 - k : 0;
      q.push_back(mk(k == 11 || k == 21, r != 0,
                     (k >= 11 && k <= 12) || (k >= 21 && k <= 26),
                     k == 27, 1'b0, r, 0));
      #1 got = obs_w[4];
      exp = q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL async_reset cyc=%0d got %s want %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_drop_saturate();
    obs_t q[$];
    obs_t got, exp;
    reset_dut();
    @(posedge clk);
    #1 start_req = 1'b1;
    repeat (400) @(posedge clk);
    #1 start_req = 1'b0;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 255));
    repeat (10) @(posedge clk);
    #2 got = obs_w[2];
    exp = q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL drop_saturate got %s want %s", fmt(got), fmt(exp));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_kill();
    test_policy_reset();
    test_policy_ignore();
    test_policy_error();
    test_async_reset();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
